// File: rtl/irrigation_scheduler_pkg.sv
// Shared definitions for the irrigation scheduler and its neighbours.
//
// Holds the 3-bit display codes that the matrix display mode selector also
// decodes, the controller state enum (its encoding is the display code, so
// the state register can drive state_code directly) and the outlet
// identifiers used by the round-robin arbiter.
package irrigation_scheduler_pkg;

   localparam logic [2:0] CODE_IDLE     = 3'd0;
   localparam logic [2:0] CODE_FILL     = 3'd1;
   localparam logic [2:0] CODE_SPRINKLE = 3'd2;
   localparam logic [2:0] CODE_DRIP     = 3'd3;
   localparam logic [2:0] CODE_SETTLE   = 3'd4;
   localparam logic [2:0] CODE_FAULT    = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE     = CODE_IDLE,
      ST_FILL     = CODE_FILL,
      ST_SPRINKLE = CODE_SPRINKLE,
      ST_DRIP     = CODE_DRIP,
      ST_SETTLE   = CODE_SETTLE,
      ST_FAULT    = CODE_FAULT
   } state_e;

   typedef enum logic {
      GRANT_SPRINKLER = 1'b0,
      GRANT_DRIPPER   = 1'b1
   } grant_e;

endpackage

// File: rtl/irrigation_scheduler_tick_timer.sv
// Slow-tick timer shared by every timed state of the irrigation scheduler.
//
// Ports:
//   clock, reset_n : fast clock, asynchronous active-low reset
//   clear_i        : forces the count to zero (used on every state change)
//   tick_i         : slow-clock pulse; the count advances only on it
//   term_i         : terminal tick count for the state currently active
//   expire_o       : high in the cycle whose tick completes term_i ticks
module irrigation_scheduler_tick_timer #(
   parameter int TIMER_W = 6
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear_i,
   input  logic               tick_i,
   input  logic [TIMER_W-1:0] term_i,
   output logic               expire_o
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W:0]   countNext;

   // Compare against the value the count is about to take, one bit wider
   // so the all-ones count cannot wrap; this lets the state machine leave
   // on the very edge that samples the terminal tick.
   assign countNext = {1'b0, count_q} + {{TIMER_W{1'b0}}, 1'b1};
   assign expire_o  = tick_i & (countNext >= {1'b0, term_i});

   // Clear wins over counting; the counter saturates at all-ones instead of
   // wrapping, so a state that ignores the timer never sees a false expiry
   // caused by a wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (tick_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: refills the tank when it runs low and shares the
// water between the sprinkler and the dripper with round-robin arbitration.
//
// Ports:
//   clock, reset_n            : fast clock, asynchronous active-low reset
//   tick                      : slow-clock pulse, all burst timing counts it
//   water_level[2:0]          : tank level 0..7
//   sprinkler_req/dripper_req : level-sensitive outlet switches
//   fault_clear               : pulse that leaves FAULT
//   fill_valve/sprinkler_on/dripper_on : valve drives, at most one high
//   state_code[2:0]           : display code of the current state
//   fault                     : high while in FAULT
module irrigation_scheduler #(
   parameter int LEVEL_LOW      = 2,
   parameter int LEVEL_HIGH     = 6,
   parameter int SPRINKLE_TICKS = 8,
   parameter int DRIP_TICKS     = 16,
   parameter int SETTLE_TICKS   = 2,
   parameter int FILL_TIMEOUT   = 32,
   parameter int TIMER_W        = 6
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tick,
   input  logic [2:0] water_level,
   input  logic       sprinkler_req,
   input  logic       dripper_req,
   input  logic       fault_clear,
   output logic       fill_valve,
   output logic       sprinkler_on,
   output logic       dripper_on,
   output logic [2:0] state_code,
   output logic       fault
);

   import irrigation_scheduler_pkg::*;

   localparam logic [2:0] LevelLowC  = 3'(LEVEL_LOW);
   localparam logic [2:0] LevelHighC = 3'(LEVEL_HIGH);

   state_e             state_q, state_d;
   grant_e             lastGrant_q, lastGrant_d;
   logic [TIMER_W-1:0] term_d;
   logic               timerClear;
   logic               timerExpire;
   logic               levelLow;
   logic               levelHigh;

   assign levelLow  = (water_level <= LevelLowC);
   assign levelHigh = (water_level >= LevelHighC);

   // Next-state and arbitration. Low water outranks any request in IDLE;
   // with both switches on, the outlet not served last time wins, and every
   // grant records who was served so contested grants strictly alternate.
   // In FILL a level success is tested before the timeout so that both in
   // the same cycle ends in SETTLE rather than FAULT.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      unique case (state_q)
         ST_IDLE: begin
            if (levelLow) begin
               state_d = ST_FILL;
            end else if (sprinkler_req && dripper_req) begin
               if (lastGrant_q == GRANT_DRIPPER) begin
                  state_d     = ST_SPRINKLE;
                  lastGrant_d = GRANT_SPRINKLER;
               end else begin
                  state_d     = ST_DRIP;
                  lastGrant_d = GRANT_DRIPPER;
               end
            end else if (sprinkler_req) begin
               state_d     = ST_SPRINKLE;
               lastGrant_d = GRANT_SPRINKLER;
            end else if (dripper_req) begin
               state_d     = ST_DRIP;
               lastGrant_d = GRANT_DRIPPER;
            end
         end
         ST_FILL: begin
            if (levelHigh) begin
               state_d = ST_SETTLE;
            end else if (timerExpire) begin
               state_d = ST_FAULT;
            end
         end
         ST_SPRINKLE: begin
            if (timerExpire || !sprinkler_req || levelLow) begin
               state_d = ST_SETTLE;
            end
         end
         ST_DRIP: begin
            if (timerExpire || !dripper_req || levelLow) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (timerExpire) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (fault_clear) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Only one timed state is ever active, so a single timer serves them
   // all: the terminal count follows the current state and the count is
   // cleared on every transition, leaving it at zero in each entry cycle.
   always_comb begin
      term_d = '1;
      unique case (state_q)
         ST_FILL:     term_d = TIMER_W'(FILL_TIMEOUT);
         ST_SPRINKLE: term_d = TIMER_W'(SPRINKLE_TICKS);
         ST_DRIP:     term_d = TIMER_W'(DRIP_TICKS);
         ST_SETTLE:   term_d = TIMER_W'(SETTLE_TICKS);
         default:     term_d = '1;
      endcase
   end

   assign timerClear = (state_d != state_q);

   irrigation_scheduler_tick_timer #(
      .TIMER_W (TIMER_W)
   ) uTimer (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear_i  (timerClear),
      .tick_i   (tick),
      .term_i   (term_d),
      .expire_o (timerExpire)
   );

   // State and arbitration history. Reset marks the dripper as last served
   // so the first contested grant goes to the sprinkler.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         lastGrant_q <= GRANT_DRIPPER;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Outputs decode the state register directly, so reset closes every
   // valve at once and only one valve can ever be open.
   assign fill_valve   = (state_q == ST_FILL);
   assign sprinkler_on = (state_q == ST_SPRINKLE);
   assign dripper_on   = (state_q == ST_DRIP);
   assign fault        = (state_q == ST_FAULT);
   assign state_code   = state_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler: a tick-counting reference
// model is compared against the DUT on every falling clock edge, and a set
// of directed scenarios pins literal expectations (fill priority, burst
// lengths, alternating grants, aborts, fill timeout and its boundary).
module tb_irrigation_scheduler;

   localparam int LevelLow     = 2;
   localparam int LevelHigh    = 6;
   localparam int SprinkleLen  = 8;
   localparam int DripLen      = 16;
   localparam int SettleLen    = 2;
   localparam int FillTimeout  = 32;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       tick;
   logic [2:0] water_level;
   logic       sprinkler_req;
   logic       dripper_req;
   logic       fault_clear;
   logic       fill_valve;
   logic       sprinkler_on;
   logic       dripper_on;
   logic [2:0] state_code;
   logic       fault;

   int assertions = 0;
   int failures   = 0;
   int tickMode   = 0;
   bit checkEn    = 1'b0;

   int mState = 0;
   int mTicks = 0;
   int mLast  = 1;

   always #5 clock = ~clock;

   irrigation_scheduler dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .tick          (tick),
      .water_level   (water_level),
      .sprinkler_req (sprinkler_req),
      .dripper_req   (dripper_req),
      .fault_clear   (fault_clear),
      .fill_valve    (fill_valve),
      .sprinkler_on  (sprinkler_on),
      .dripper_on    (dripper_on),
      .state_code    (state_code),
      .fault         (fault)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertions++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model in terms of "ticks seen since entering the mode":
   // state codes are the display codes, mLast is 0 for sprinkler, 1 for
   // dripper.
   task automatic modelStep();
      int  next;
      int  t;
      bit  low;
      bit  high;
      low  = (int'(water_level) <= LevelLow);
      high = (int'(water_level) >= LevelHigh);
      t    = mTicks + (tick ? 1 : 0);
      next = mState;
      case (mState)
         0: begin
            if (low) next = 1;
            else if (sprinkler_req && dripper_req) next = (mLast == 1) ? 2 : 3;
            else if (sprinkler_req) next = 2;
            else if (dripper_req) next = 3;
         end
         1: begin
            if (high) next = 4;
            else if (t >= FillTimeout) next = 7;
         end
         2: if (t >= SprinkleLen || !sprinkler_req || low) next = 4;
         3: if (t >= DripLen || !dripper_req || low) next = 4;
         4: if (t >= SettleLen) next = 0;
         7: if (fault_clear) next = 0;
         default: next = 0;
      endcase
      if (next != mState) begin
         if (next == 2) mLast = 0;
         if (next == 3) mLast = 1;
         mTicks = 0;
      end else begin
         mTicks = t;
      end
      mState = next;
   endtask

   // The model advances on the same edges as the DUT and resets with it.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mState = 0;
         mTicks = 0;
         mLast  = 1;
      end else begin
         modelStep();
      end
   end

   // Every falling edge, compare all outputs with the model and check that
   // no two valves are ever open together.
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("state_code", int'(state_code), mState);
         checkOutput("fill_valve", int'(fill_valve), (mState == 1) ? 1 : 0);
         checkOutput("sprinkler_on", int'(sprinkler_on), (mState == 2) ? 1 : 0);
         checkOutput("dripper_on", int'(dripper_on), (mState == 3) ? 1 : 0);
         checkOutput("fault", int'(fault), (mState == 7) ? 1 : 0);
         checkOutput("one_valve", (int'(fill_valve) + int'(sprinkler_on) + int'(dripper_on)) <= 1 ? 1 : 0, 1);
      end
   end

   // Advances n cycles; inputs change just after each falling edge.
   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         case (tickMode)
            0:       tick = ($urandom_range(0, 2) == 0);
            1:       tick = 1'b0;
            default: tick = 1'b1;
         endcase
      end
   endtask

   task automatic waitModelState(input int code, input int budget, input string name);
      int k;
      k = 0;
      while (mState != code && k < budget) begin
         waitCycles(1);
         k++;
      end
      assertions++;
      if (mState != code) begin
         failures++;
         $display("[TB] FAIL %s timeout: state %0d, required %0d", name, mState, code);
      end
   endtask

   task automatic applyStimulus();
      int grantIdx;
      int sT;
      int dT;
      int setT;
      int fillTicks;
      int k;
      bit prevS;
      bit prevD;
      bit prevSet;

      reset_n = 1'b0;
      tick = 1'b0;
      water_level = 3'd5;
      sprinkler_req = 1'b0;
      dripper_req = 1'b0;
      fault_clear = 1'b0;
      waitCycles(2);
      checkEn = 1'b1;
      waitCycles(1);
      reset_n = 1'b1;
      waitCycles(1);
      checkOutput("reset_code", int'(state_code), 0);
      checkOutput("reset_valves", int'(fill_valve) + int'(sprinkler_on) + int'(dripper_on) + int'(fault), 0);

      // Low water beats a pending request; filling ends when level is high.
      water_level = 3'd1;
      sprinkler_req = 1'b1;
      waitCycles(1);
      checkOutput("fill_priority", int'(state_code), 1);
      k = 0;
      while (k < 10) begin
         waitCycles(1);
         k += int'(tick);
      end
      water_level = 3'd6;
      waitCycles(1);
      checkOutput("fill_done_settle", int'(state_code), 4);
      waitModelState(2, 200, "sprinkle_after_fill");
      checkOutput("sprinkle_after_fill", int'(state_code), 2);
      waitCycles(2);
      checkOutput("sprinkler_before_reset", int'(sprinkler_on), 1);
      #2 reset_n = 1'b0;
      #1 checkOutput("async_reset_sprinkler", int'(sprinkler_on), 0);
      checkOutput("async_reset_code", int'(state_code), 0);
      waitCycles(2);
      reset_n = 1'b1;
      sprinkler_req = 1'b0;
      water_level = 3'd5;

      // Both switches held: grants alternate S,D,S,D with full bursts.
      sprinkler_req = 1'b1;
      dripper_req = 1'b1;
      grantIdx = 0; sT = 0; dT = 0; setT = 0;
      prevS = 1'b0; prevD = 1'b0; prevSet = 1'b0;
      for (int c = 0; c < 600; c++) begin
         waitCycles(1);
         if ((sprinkler_on && !prevS) || (dripper_on && !prevD)) begin
            checkOutput("grant_order", dripper_on ? 1 : 0, grantIdx % 2);
            grantIdx++;
         end
         if (sprinkler_on) sT += int'(tick);
         else if (prevS) begin checkOutput("sprinkle_ticks", sT, SprinkleLen); sT = 0; end
         if (dripper_on) dT += int'(tick);
         else if (prevD) begin checkOutput("drip_ticks", dT, DripLen); dT = 0; end
         if (state_code == 3'd4) setT += int'(tick);
         else if (prevSet) begin checkOutput("settle_ticks", setT, SettleLen); setT = 0; end
         prevS = sprinkler_on;
         prevD = dripper_on;
         prevSet = (state_code == 3'd4);
      end
      checkOutput("grant_count_min", (grantIdx >= 4) ? 1 : 0, 1);

      // Dripper switch released mid-burst, then a low-water abort.
      sprinkler_req = 1'b0;
      dripper_req = 1'b0;
      waitModelState(0, 300, "idle_before_drip");
      dripper_req = 1'b1;
      waitModelState(3, 50, "drip_start");
      waitCycles(3);
      dripper_req = 1'b0;
      waitCycles(1);
      checkOutput("drip_drop", int'(state_code), 4);
      waitModelState(0, 100, "idle_after_drop");
      dripper_req = 1'b1;
      waitModelState(3, 50, "drip_start2");
      waitCycles(2);
      water_level = 3'd2;
      waitCycles(1);
      checkOutput("drip_low_abort", int'(state_code), 4);
      waitModelState(0, 100, "idle_after_abort");
      waitCycles(1);
      checkOutput("refill_after_abort", int'(state_code), 1);
      dripper_req = 1'b0;

      // Dry tank: the fill times out on its 32nd tick.
      water_level = 3'd0;
      fillTicks = int'(tick);
      k = 0;
      while (!fault && k < 400) begin
         waitCycles(1);
         k++;
         if (fill_valve) fillTicks += int'(tick);
      end
      checkOutput("fill_timeout_ticks", fillTicks, FillTimeout);
      checkOutput("fault_code", int'(state_code), 7);
      sprinkler_req = 1'b1;
      dripper_req = 1'b1;
      waitCycles(5);
      checkOutput("fault_ignores_req", int'(state_code), 7);
      sprinkler_req = 1'b0;
      dripper_req = 1'b0;
      fault_clear = 1'b1;
      waitCycles(1);
      fault_clear = 1'b0;
      checkOutput("fault_clear_idle", int'(state_code), 0);
      waitCycles(1);
      checkOutput("refill_after_clear", int'(state_code), 1);

      // Level reaches high on the very tick of the timeout: success wins.
      fillTicks = int'(tick);
      k = 0;
      while (fillTicks < FillTimeout - 1 && k < 400) begin
         waitCycles(1);
         k++;
         fillTicks += int'(tick);
      end
      tickMode = 2;
      waitCycles(1);
      water_level = 3'd6;
      tickMode = 0;
      waitCycles(1);
      checkOutput("fill_boundary_settle", int'(state_code), 4);
      checkOutput("fill_boundary_no_fault", int'(fault), 0);

      // Random traffic checked cycle by cycle against the model.
      water_level = 3'd5;
      for (int c = 0; c < 3000; c++) begin
         waitCycles(1);
         fault_clear = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) == 0) sprinkler_req = ~sprinkler_req;
         if ($urandom_range(0, 9) == 0) dripper_req = ~dripper_req;
         if ($urandom_range(0, 11) == 0) water_level = 3'($urandom_range(0, 7));
      end
      fault_clear = 1'b0;
      waitCycles(2);
   endtask

   initial begin
      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
Controller that sequences the water tank and the two irrigation outlets (sprinkler, dripper). It refills the tank when the level is low and arbitrates round-robin between the sprinkler and dripper switch requests. Each watering burst is a fixed number of slow ticks. A 3-bit status code drives the matrix display's state image.

Parameters:
LEVEL_LOW, 2, watering is blocked and refill starts when level <= this value
LEVEL_HIGH, 6, refill stops when level >= this value (must be > LEVEL_LOW)
SPRINKLE_TICKS, 8, sprinkler burst length in ticks
DRIP_TICKS, 16, dripper burst length in ticks
SETTLE_TICKS, 2, dead time after any valve closes
FILL_TIMEOUT, 32, maximum number of fill ticks before a fault
TIMER_W, 6, timer width (must hold the largest tick count)

Ports:
clock  in  1  system clock (fast clock domain)
reset_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle pulse from the slow-clock divider; all timers advance only on tick
water_level  in  3  tank level, unsigned 0..7
sprinkler_req  in  1  sprinkler switch, level-sensitive
dripper_req  in  1  dripper switch, level-sensitive
fault_clear  in  1  one-cycle pulse that leaves FAULT
fill_valve  out  1  tank inlet open
sprinkler_on  out  1  sprinkler outlet open
dripper_on  out  1  dripper outlet open
state_code  out  3  display code: IDLE=0, FILL=1, SPRINKLE=2, DRIP=3, SETTLE=4, FAULT=7
fault  out  1  high in FAULT

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, timer=0, last_grant=dripper (so the first contested grant goes to the sprinkler).
  - All outputs are 0, including state_code=0.
  - Reset asserted mid-burst closes all valves immediately.
- Output timing: outputs are Moore decodes of the state register, with no extra register stage. An input change sampled at edge N is reflected in the outputs after edge N.
- At most one of fill_valve, sprinkler_on, dripper_on is high at any time. This is a hard invariant.
- IDLE:
  - If water_level <= LEVEL_LOW, go to FILL. This takes priority over requests.
  - Otherwise, if exactly one request is high, go to that outlet's state.
  - If both are high, grant the outlet that was not last_grant, then update last_grant.
  - Otherwise stay in IDLE.
- FILL: fill_valve=1. The timer clears on entry and increments on tick.
  - If water_level >= LEVEL_HIGH, go to SETTLE.
  - Else, if the timer reaches FILL_TIMEOUT on a tick, go to FAULT.
- SPRINKLE / DRIP: the outlet is on, the timer clears on entry and increments on tick. Exit to SETTLE on the first of:
  - the timer reaching SPRINKLE_TICKS or DRIP_TICKS;
  - the granted request dropping to 0 (checked every cycle, not only on tick);
  - water_level <= LEVEL_LOW (low-water abort).
- SETTLE: all valves are closed. The timer clears on entry. After SETTLE_TICKS ticks, go to IDLE.
- FAULT: all valves are closed and fault=1. Exit to IDLE only on fault_clear. Requests are ignored while in FAULT.
- fault_clear outside FAULT is ignored.
- Simultaneous events in the same cycle:
  - Level reaching LEVEL_HIGH and the fill timeout together: go to SETTLE (success wins).
  - Request drop and burst expiry together: go to SETTLE, with the same result either way.
- Timer behaviour:
  - The timer saturates and never wraps.
  - A tick arriving in the entry cycle counts.
  - Burst length is measured in ticks, so the number of clock cycles in a burst varies with tick phase.
- Arbitration fairness: with both requests held high, grants strictly alternate S, D, S, D, separated by SETTLE periods.
- Inputs are assumed synchronous to clock. Switch synchronisers sit upstream and are not part of this block.

Decomposition:
- Shared package holds:
  - the state enum, whose encoding equals the state_code values;
  - the state_code constants, reused by the matrix display mode selector.
- One sub-module: tick_timer, a clear/enable/saturating counter with a terminal-count compare. It is instantiated once and shared across states, since only one timed state is active at a time.

Test Plan:
- Reset with level=5 and both requests 0 -> IDLE, all outputs 0, state_code=0. Assert reset_n=0 mid-SPRINKLE -> sprinkler_on drops without waiting for a clock edge.
- Level=1 and sprinkler_req=1 -> FILL (code 1), even with the request high.
  - Ramp the level to 6 after 10 ticks -> SETTLE for 2 ticks -> IDLE -> SPRINKLE.
- Level=5 with both requests held high for 100 ticks -> grant order SPRINKLE(8 ticks), SETTLE(2), DRIP(16), SETTLE(2), SPRINKLE, and so on. Outlets are never high together.
- Level=5 in DRIP: drop dripper_req between ticks -> SETTLE on the next edge. Separately, drop the level to 2 mid-DRIP -> SETTLE -> IDLE -> FILL.
- Level held at 0 in FILL -> FAULT (code 7, fault=1) on the 32nd tick. Requests are ignored in FAULT. fault_clear pulse -> IDLE -> FILL again.
- Fill boundary: level reaches 6 on the same tick the timer hits 32 -> SETTLE, not FAULT.
